// File: rtl/lsu_subword_ctrl.sv
// MEM-stage load/store controller in front of a word-wide data memory.
// Extends sub-word loads and turns sb/sh into read-modify-write word cycles.
module lsu_subword_ctrl #(
    parameter int MEM_AW           = 8,
    parameter bit ERR_ON_UNALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [MEM_AW+1:0] addr_r;
    logic [2:0]  size_r;
    logic [15:0] wdata_r;
    logic [31:0] wr_word_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        accept_s;
    logic        illegal_s;
    logic        misal_s;
    logic        error_s;
    logic [31:0] aligned_addr_s;
    logic        unused_addr_s;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  size,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = word;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept_s  = req_valid && (state_r == S_IDLE);
    assign illegal_s = (req_size == 3'b011) || (req_size[2:1] == 2'b11) || (req_we && req_size[2]);
    assign misal_s   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign error_s   = illegal_s || (misal_s && ERR_ON_UNALIGNED);
    // Upper address bits alias onto the same words by design.
    assign unused_addr_s = ^req_addr[31:MEM_AW+2];

    // Alignment applied when misaligned accesses are tolerated rather than rejected.
    always_comb begin
        aligned_addr_s = req_addr;
        if (!ERR_ON_UNALIGNED && (req_size[1:0] == 2'b01)) begin
            aligned_addr_s = {req_addr[31:1], 1'b0};
        end else if (!ERR_ON_UNALIGNED && (req_size[1:0] == 2'b10)) begin
            aligned_addr_s = {req_addr[31:2], 2'b00};
        end else begin
            aligned_addr_s = req_addr;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_s = S_IDLE;
                end else if (error_s) begin
                    state_s = S_RESP;
                end else if (!req_we) begin
                    state_s = S_LD;
                end else if (req_size[1:0] == 2'b10) begin
                    state_s = S_WR;
                end else begin
                    state_s = S_RMW_RD;
                end
            end
            S_LD:     state_s = S_RESP;
            S_RMW_RD: state_s = S_WR;
            S_WR:     state_s = S_RESP;
            S_RESP:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Request capture, load extension and store-word merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            size_r    <= 3'b000;
            wdata_r   <= 16'h0000;
            wr_word_r <= 32'h00000000;
            rdata_r   <= 32'h00000000;
            err_r     <= 1'b0;
        end else if (accept_s) begin
            addr_r    <= aligned_addr_s[MEM_AW+1:0];
            size_r    <= req_size;
            wdata_r   <= req_wdata[15:0];
            wr_word_r <= req_wdata;
            rdata_r   <= 32'h00000000;
            err_r     <= error_s;
        end else if (state_r == S_LD) begin
            rdata_r <= extend_load(mem_read_data, size_r, addr_r[1:0]);
        end else if (state_r == S_RMW_RD) begin
            wr_word_r <= merge_store(mem_read_data, wdata_r, size_r[1:0], addr_r[1:0]);
        end else begin
            rdata_r   <= rdata_r;
            wr_word_r <= wr_word_r;
        end
    end

    assign req_ready      = (state_r == S_IDLE);
    assign resp_valid     = (state_r == S_RESP);
    assign resp_err       = (state_r == S_RESP) && err_r;
    assign resp_rdata     = rdata_r;
    assign mem_memread    = (state_r == S_LD) || (state_r == S_RMW_RD);
    assign mem_memwrite   = (state_r == S_WR);
    assign mem_address    = {{(32-MEM_AW){1'b0}}, addr_r[MEM_AW+1:2]};
    assign mem_write_data = wr_word_r;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Scoreboard bench for lsu_subword_ctrl against an array-based memory and reference model.
module tb_lsu_subword_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_read_data;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          last_acc = -1;
    int          last_lat = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] wa;
        logic [31:0] wd;
        int          acc;
    } exp_t;

    exp_t q[$];

    lsu_subword_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_address[7:0]];

    // Word memory: whole-word writes land at the posedge closing a memwrite cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_memwrite) mem[mem_address[7:0]] = mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic [31:0] word, b, h, mask, newv;
        logic [7:0] idx;
        int sh;
        logic bad;
        idx  = addr[9:2];
        word = ref_mem[idx];
        sh   = int'(addr[1:0]) * 8;
        bad  = (size == 3'd3) || (size == 3'd6) || (size == 3'd7) || (we && size[2]) ||
               (size[1:0] == 2'd1 && addr[0]) || (size[1:0] == 2'd2 && addr[1:0] != 2'd0);
        e.rdata = 32'h0; e.err = 1'b0; e.reads = 0; e.writes = 0;
        e.wa = {24'h0, idx}; e.wd = 32'h0; e.acc = 0; e.lat = 0;
        if (bad) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            e.reads = 1;
            e.lat = 2;
            b = (word >> sh) & 32'hFF;
            h = (word >> sh) & 32'hFFFF;
            case (size)
                3'd0: e.rdata = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
                3'd4: e.rdata = b;
                3'd1: e.rdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
                3'd5: e.rdata = h;
                default: e.rdata = word;
            endcase
        end else begin
            e.writes = 1;
            if (size == 3'd2) begin
                e.lat = 2;
                newv = wdata;
            end else begin
                e.reads = 1;
                e.lat = 3;
                mask = ((size == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
                newv = (word & ~mask) | ((wdata << sh) & mask);
            end
            ref_mem[idx] = newv;
            e.wd = newv;
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit junk);
        exp_t e;
        int n;
        e = model(we, size, addr, wdata);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            last_acc = -1;
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        e.acc = cyc + 1;
        if (last_acc >= 0) chk("issue_gap", e.acc - last_acc, last_lat + 1);
        last_acc = e.acc;
        last_lat = e.lat;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (junk) begin
            req_we = 1'($urandom_range(0, 1)); req_size = 3'($urandom_range(0, 7));
            req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        req_valid = 1'b0;
        last_acc = -1;
    endtask

    // Monitor: pulse accounting per transaction and response comparison.
    initial begin
        int rd, wr;
        logic [31:0] wa, wd;
        exp_t e;
        rd = 0; wr = 0; wa = 32'h0; wd = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd = 0;
                wr = 0;
            end else begin
                chk("rd_wr_exclusive", {31'h0, mem_memread & mem_memwrite}, 32'd0);
                if (mem_memread) rd++;
                if (mem_memwrite) begin
                    wr++;
                    wa = mem_address;
                    wd = mem_write_data;
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                        chk("latency", cyc - e.acc + 1, e.lat);
                        chk("memread_pulses", rd, e.reads);
                        chk("memwrite_pulses", wr, e.writes);
                        if (e.writes != 0) begin
                            chk("write_addr", wa, e.wa);
                            chk("write_data", wd, e.wd);
                        end
                    end
                    rd = 0;
                    wr = 0;
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        chk("rst_rd_wr", {30'h0, mem_memread, mem_memwrite}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 3'd2, 32'h00, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h00, 32'h11223344, 1'b0);
        issue(1'b0, 3'd0, 32'h03, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h00, 32'h000000F0, 1'b0);
        issue(1'b0, 3'd0, 32'h00, 32'h0, 1'b0);
        issue(1'b0, 3'd4, 32'h00, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h04, 32'h80007FFF, 1'b0);
        issue(1'b0, 3'd1, 32'h06, 32'h0, 1'b0);
        issue(1'b0, 3'd5, 32'h06, 32'h0, 1'b0);
        issue(1'b0, 3'd1, 32'h04, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h08, 32'hAABBCCDD, 1'b0);
        issue(1'b1, 3'd0, 32'h09, 32'h00000055, 1'b1);
        issue(1'b0, 3'd2, 32'h08, 32'h0, 1'b0);
        issue(1'b1, 3'd1, 32'h0A, 32'h00001234, 1'b1);
        issue(1'b0, 3'd2, 32'h08, 32'h0, 1'b0);
        issue(1'b0, 3'd2, 32'h02, 32'h0, 1'b0);
        issue(1'b1, 3'd1, 32'h01, 32'h0, 1'b0);
        issue(1'b0, 3'd3, 32'h00, 32'h0, 1'b0);
        issue(1'b1, 3'd4, 32'h00, 32'h0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  ($urandom_range(0, 1) == 1));
        end
        drain();

        // Reset during the read half of an sb: the word must stay untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd0; req_addr = 32'h0D; req_wdata = 32'h000000A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!mem_memread && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rmw_read_seen", {31'h0, mem_memread}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_memread", {31'h0, mem_memread}, 32'd0);
        chk("midrst_memwrite", {31'h0, mem_memwrite}, 32'd0);
        chk("midrst_ready", {31'h0, req_ready}, 32'd1);
        chk("midrst_mem_addr", mem_address, 32'h0);
        chk("midrst_mem_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_memwrite_held", {31'h0, mem_memwrite}, 32'd0);
        rst_n = 1'b1;
        chk("midrst_word_kept", mem[3], ref_mem[3]);
        issue(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
